// File: rtl/id_scoreboard_hazard_unit_if.sv
// rtl/id_scoreboard_hazard_unit_if.sv - ID-stage issue/hazard bundle between decode and the scoreboard
interface id_scoreboard_hazard_unit_if #(
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  busywait;
  logic                  flush;
  logic                  issue_valid_i;
  logic                  issue_wr_en_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic [1:0]            issue_kind_i;
  logic [REG_ADDR_W-1:0] rs1_label_i;
  logic [REG_ADDR_W-1:0] rs2_label_i;
  logic                  rs1_used_i;
  logic                  rs2_used_i;
  logic                  stall;
  logic [REG_COUNT-1:0]  busy_mask_o;
  logic                  pending_o;
  logic [31:0]           stall_count_o;

  // Decode side: presents the instruction, observes the stall
  modport master (
    output busywait, flush, issue_valid_i, issue_wr_en_i, issue_rd_i, issue_kind_i,
    output rs1_label_i, rs2_label_i, rs1_used_i, rs2_used_i,
    input  stall, busy_mask_o, pending_o, stall_count_o
  );

  // Scoreboard side
  modport slave (
    input  busywait, flush, issue_valid_i, issue_wr_en_i, issue_rd_i, issue_kind_i,
    input  rs1_label_i, rs2_label_i, rs1_used_i, rs2_used_i,
    output stall, busy_mask_o, pending_o, stall_count_o
  );
endinterface

// File: rtl/id_scoreboard_hazard_unit.sv
// rtl/id_scoreboard_hazard_unit.sv - per-register countdown scoreboard driving the ID RAW/WAW stall (optional SCOREBOARD_STATS_EN)
module id_scoreboard_hazard_unit #(
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int LONG_LAT   = 4,
  parameter int CNT_W      = 3
) (
  input logic                        clk_i,
  input logic                        rst_i,
  id_scoreboard_hazard_unit_if.slave sb
);

  localparam int LBL_N   = 1 << REG_ADDR_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [CNT_W-1:0] LOAD_LAT_C = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] LONG_LAT_C = CNT_W'(LONG_LAT);

  // Refuse to build with latencies the counters cannot represent
  if (LOAD_LAT < 1 || LOAD_LAT > CNT_MAX || LONG_LAT < 1 || LONG_LAT > CNT_MAX ||
      REG_COUNT < 2 || REG_COUNT > LBL_N) begin : g_bad_cfg
    $error("id_scoreboard_hazard_unit: illegal latency/width/register-count configuration");
  end

  // Entry 0 is never stored: x0 is architecturally never busy
  logic [CNT_W-1:0] cnt_q [1:REG_COUNT-1];

  // Full label-space view so any label can be looked up; unmapped labels read as idle
  logic [CNT_W-1:0] cnt_view [LBL_N];

  for (genvar r = 0; r < LBL_N; r++) begin : g_view
    if (r >= 1 && r < REG_COUNT) begin : g_live
      assign cnt_view[r] = cnt_q[r];
    end else begin : g_idle
      assign cnt_view[r] = '0;
    end
  end

  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] kind);
    case (kind)
      2'd1:    lat_of = LOAD_LAT_C;
      2'd2:    lat_of = LONG_LAT_C;
      default: lat_of = '0;
    endcase
  endfunction

  logic [CNT_W-1:0]     rd_lat;
  logic                 raw_hit;
  logic                 waw_hit;
  logic                 stall_c;
  logic                 issue_fire;
  logic                 alloc;
  logic [REG_COUNT-1:0] busy_mask;

  // Hazard detection and issue qualification; stall is visible even during busywait
  always_comb begin
    rd_lat  = lat_of(sb.issue_kind_i);
    raw_hit = (sb.rs1_used_i && (sb.rs1_label_i != '0) && (cnt_view[sb.rs1_label_i] != '0)) ||
              (sb.rs2_used_i && (sb.rs2_label_i != '0) && (cnt_view[sb.rs2_label_i] != '0));
    // A younger write may not land before an older one to the same register
    waw_hit = sb.issue_wr_en_i && (sb.issue_rd_i != '0) && (cnt_view[sb.issue_rd_i] > rd_lat);
    stall_c    = sb.issue_valid_i && !sb.flush && (raw_hit || waw_hit);
    issue_fire = sb.issue_valid_i && !stall_c && !sb.busywait && !sb.flush;
    alloc      = issue_fire && sb.issue_wr_en_i && (sb.issue_rd_i != '0) && (rd_lat != '0);
  end

  // Countdown per register: new allocation wins over the decrement, memory stall freezes all
  always_ff @(posedge clk_i) begin
    for (int r = 1; r < REG_COUNT; r++) begin
      if (rst_i) begin
        cnt_q[r] <= '0;
      end else if (!sb.busywait) begin
        if (alloc && (sb.issue_rd_i == REG_ADDR_W'(r))) begin
          cnt_q[r] <= rd_lat;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
      end
    end
  end

  // Busy summary for the pipeline and debug
  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      busy_mask[r] = (cnt_q[r] != '0);
    end
  end

  assign sb.stall       = stall_c;
  assign sb.busy_mask_o = busy_mask;
  assign sb.pending_o   = |busy_mask;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;

  // Cycles genuinely lost to hazards; memory-stall cycles are not charged here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_c && !sb.busywait && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign sb.stall_count_o = stall_cnt_q;
`else
  assign sb.stall_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_id_scoreboard_hazard_unit.sv
// tb/tb_id_scoreboard_hazard_unit.sv - randomized check of the ID scoreboard against a ready-time model
module tb_id_scoreboard_hazard_unit;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LOAD_LAT   = 1;
  localparam int LONG_LAT   = 4;
  localparam int CNT_W      = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  id_scoreboard_hazard_unit_if #(.REG_COUNT(REG_COUNT), .REG_ADDR_W(REG_ADDR_W)) bus ();

  id_scoreboard_hazard_unit #(
    .REG_COUNT (REG_COUNT),
    .REG_ADDR_W(REG_ADDR_W),
    .LOAD_LAT  (LOAD_LAT),
    .LONG_LAT  (LONG_LAT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sb   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: a time base that only advances on non-busywait cycles, and the
  // time at which each register's result becomes forwardable.
  longint t_now;
  longint ready_at [REG_COUNT];
  longint stat_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_rem(input int r);
    longint d;
    if (r == 0 || r >= REG_COUNT) return 0;
    d = ready_at[r] - t_now;
    return (d > 0) ? int'(d) : 0;
  endfunction

  function automatic int m_lat(input int kind);
    if (kind == 1) return LOAD_LAT;
    if (kind == 2) return LONG_LAT;
    return 0;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance, update the model
  task automatic step(input bit r, input bit bw, input bit fl, input bit v, input bit we,
                      input int rd, input int kind, input int r1, input int r2,
                      input bit u1, input bit u2);
    bit raw, waw, exp_stall, fire;
    logic [REG_COUNT-1:0] exp_mask;
    rst                   = r;
    bus.busywait          = bw;
    bus.flush             = fl;
    bus.issue_valid_i     = v;
    bus.issue_wr_en_i     = we;
    bus.issue_rd_i        = REG_ADDR_W'(rd);
    bus.issue_kind_i      = 2'(kind);
    bus.rs1_label_i       = REG_ADDR_W'(r1);
    bus.rs2_label_i       = REG_ADDR_W'(r2);
    bus.rs1_used_i        = u1;
    bus.rs2_used_i        = u2;
    @(negedge clk);
    raw = (u1 && m_rem(r1) > 0) || (u2 && m_rem(r2) > 0);
    waw = we && rd != 0 && m_rem(rd) > m_lat(kind);
    exp_stall = v && !fl && (raw || waw);
    exp_mask = '0;
    for (int i = 1; i < REG_COUNT; i++) exp_mask[i] = (m_rem(i) > 0);
    check_eq("stall", 64'(bus.stall), 64'(exp_stall));
    check_eq("busy_mask", 64'(bus.busy_mask_o), 64'(exp_mask));
    check_eq("pending", 64'(bus.pending_o), 64'(exp_mask != '0));
`ifdef SCOREBOARD_STATS_EN
    check_eq("stall_count", 64'(bus.stall_count_o), 64'(stat_cnt));
`else
    check_eq("stall_count", 64'(bus.stall_count_o), 64'd0);
`endif
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < REG_COUNT; i++) ready_at[i] = 0;
      stat_cnt = 0;
    end else if (!bw) begin
      if (exp_stall && stat_cnt < 64'hFFFF_FFFF) stat_cnt++;
      fire = v && !exp_stall && !fl;
      if (fire && we && rd != 0 && m_lat(kind) != 0)
        ready_at[rd] = t_now + 1 + m_lat(kind);
      t_now++;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int pick_label();
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, REG_COUNT - 1));
  endfunction

  initial begin
    t_now    = 0;
    stat_cnt = 0;
    for (int i = 0; i < REG_COUNT; i++) ready_at[i] = 0;
    bus.busywait = 0; bus.flush = 0; bus.issue_valid_i = 0; bus.issue_wr_en_i = 0;
    bus.issue_rd_i = '0; bus.issue_kind_i = '0; bus.rs1_label_i = '0; bus.rs2_label_i = '0;
    bus.rs1_used_i = 0; bus.rs2_used_i = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle();

    // Load-use on x5, then consumer
    step(0, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 6, 0, 5, 0, 1, 0);
    step(0, 0, 0, 1, 1, 6, 0, 5, 0, 1, 0);
    idle();

    // Long op on x7, consumer through rs2
    step(0, 0, 0, 1, 1, 7, 2, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1, 1, 8, 0, 1, 7, 1, 1);
    idle();

    // Load x3 under a 3-cycle memory stall
    step(0, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 1, 0, 0, 0, 3, 0, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0, 0, 3, 0, 1, 0);

    // WAW: mul x9 then load x9
    step(0, 0, 0, 1, 1, 9, 2, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0);
    idle();

    // x0 writes, flush over a hazard on x4
    step(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 4, 2, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 4, 2, 4, 4, 1, 1);
    step(0, 0, 1, 1, 1, 10, 2, 4, 0, 1, 0);
    repeat (3) idle();

    // Reset while x6 is pending
    step(0, 0, 0, 1, 1, 6, 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 6, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0, 0, 6, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 6, 0, 1, 0);

    // Randomized traffic with occasional memory stalls, flushes and resets
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 75,
           pick_label(),
           int'($urandom_range(0, 3)),
           pick_label(), pick_label(),
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
